// File: rtl/lh_pkg.sv
// Shared constants, FSM encodings and byte helpers for the light-hash sequencing controller.
// The S-box table is the standard AES-128 forward substitution box.
package lh_pkg;

  localparam int unsigned LH_ROUNDS_DEFAULT = 32;
  localparam logic [63:0] LH_IV_DEFAULT     = 64'h0;

  localparam logic [7:0] UPPER_LO = 8'h41;
  localparam logic [7:0] UPPER_HI = 8'h5A;
  localparam logic [7:0] LOWER_LO = 8'h61;
  localparam logic [7:0] LOWER_HI = 8'h7A;

  // Wide enough for 8*64-1, the step count at the largest legal ROUNDS
  localparam int unsigned STEP_CNT_W = 9;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ABSORB = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes128_sbox(input logic [7:0] x);
    return SBOX_TABLE[x];
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= UPPER_LO) && (c <= UPPER_HI)) || ((c >= LOWER_LO) && (c <= LOWER_HI));
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] w;
    w = {x, x} << n;
    return w[15:8];
  endfunction

endpackage

// File: rtl/lh_step_unit.sv
// One absorption step: reads H[(i+2) mod 8], mixes in the message byte, rotates by i and
// substitutes through the S-box; the result is written back to H[i] by the controller.
module lh_step_unit
  import lh_pkg::*;
(
  input  logic [63:0] h,
  input  logic [7:0]  m_reg,
  input  logic [2:0]  idx,
  output logic [7:0]  new_byte,
  output logic [2:0]  wr_idx
);

  logic [2:0] src_idx;
  logic [7:0] src_byte;
  logic [7:0] mixed;

  always_comb begin
    src_idx  = idx + 3'd2;
    src_byte = h[{src_idx, 3'b000} +: 8];
    mixed    = rotl8(src_byte ^ m_reg, idx);
    new_byte = aes128_sbox(mixed);
    wr_idx   = idx;
  end

endmodule

// File: rtl/lh_seq_ctrl.sv
// Light-hash sequencing controller: accepts letters, absorbs each one over 8*ROUNDS
// single-S-box steps into an 8-byte state, then streams the digest out byte by byte.
module lh_seq_ctrl
  import lh_pkg::*;
#(
  parameter int unsigned ROUNDS = LH_ROUNDS_DEFAULT,
  parameter logic [63:0] IV     = LH_IV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m_valid,
  output logic       m_ready,
  input  logic       m_last,
  input  logic [7:0] ptxt_char,
  output logic       digest_valid,
  input  logic       digest_ready,
  output logic [7:0] digest_char,
  output logic       digest_last,
  output logic       hash_ready,
  output logic       err_invalid_ptxt_char,
  output logic       busy
);

  localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(8 * ROUNDS - 1);

  logic [1:0]            state_q, state_d;
  logic [63:0]           h_q, h_d;
  logic [7:0]            m_reg_q, m_reg_d;
  logic                  last_q, last_d;
  logic [STEP_CNT_W-1:0] j_q, j_d;
  logic [2:0]            k_q, k_d;
  logic                  err_q, err_d;

  logic [7:0] step_byte;
  logic [2:0] wr_idx;

  lh_step_unit u_step (
    .h        (h_q),
    .m_reg    (m_reg_q),
    .idx      (j_q[2:0]),
    .new_byte (step_byte),
    .wr_idx   (wr_idx)
  );

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    m_reg_d      = m_reg_q;
    last_d       = last_q;
    j_d          = j_q;
    k_d          = k_q;
    err_d        = err_q;
    m_ready      = 1'b0;
    digest_valid = 1'b0;
    digest_char  = 8'h00;
    digest_last  = 1'b0;
    hash_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        m_ready = 1'b1;
        if (m_valid) begin
          m_reg_d = ptxt_char;
          last_d  = m_last;
          if (is_letter(ptxt_char)) begin
            state_d = ST_ABSORB;
            j_d     = '0;
          end else begin
            err_d = 1'b1;
            if (m_last) state_d = ST_OUT;
          end
        end
      end
      ST_ABSORB: begin
        h_d[{wr_idx, 3'b000} +: 8] = step_byte;
        j_d = j_q + 1'b1;
        if (j_q == LAST_STEP) begin
          j_d     = '0;
          state_d = last_q ? ST_OUT : ST_IDLE;
        end
      end
      ST_OUT: begin
        digest_valid = 1'b1;
        digest_char  = h_q[{k_q, 3'b000} +: 8];
        digest_last  = (k_q == 3'd7);
        if (digest_ready) begin
          k_d = k_q + 3'd1;
          // Final byte accepted: re-arm for the next message
          if (k_q == 3'd7) begin
            hash_ready = 1'b1;
            h_d        = IV;
            err_d      = 1'b0;
            k_d        = 3'd0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= IV;
      m_reg_q <= 8'h00;
      last_q  <= 1'b0;
      j_q     <= '0;
      k_q     <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_reg_q <= m_reg_d;
      last_q  <= last_d;
      j_q     <= j_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  assign err_invalid_ptxt_char = err_q;
  assign busy                  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lh_seq_ctrl.sv
// Directed bench for lh_seq_ctrl; digests are predicted by an independent byte-level model
// whose S-box is derived from GF(2^8) inversion plus the AES affine map.
module tb_lh_seq_ctrl;

  localparam int unsigned ROUNDS = 32;
  localparam logic [63:0] IV     = 64'h0;
  // A letter accepted at edge t frees m_ready after edge t+8*ROUNDS; the next handshake is one edge later
  localparam int HS_GAP = 8 * ROUNDS + 1;

  logic       clk;
  logic       rst_n;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic [7:0] ptxt_char;
  logic       digest_valid;
  logic       digest_ready;
  logic [7:0] digest_char;
  logic       digest_last;
  logic       hash_ready;
  logic       err_invalid_ptxt_char;
  logic       busy;

  int compareCount = 0;
  int failCount    = 0;
  int cycleCount   = 0;

  logic [7:0] modelH [8];
  logic [7:0] refTable [256];

  lh_seq_ctrl #(.ROUNDS(ROUNDS), .IV(IV)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .m_valid               (m_valid),
    .m_ready               (m_ready),
    .m_last                (m_last),
    .ptxt_char             (ptxt_char),
    .digest_valid          (digest_valid),
    .digest_ready          (digest_ready),
    .digest_char           (digest_char),
    .digest_last           (digest_last),
    .hash_ready            (hash_ready),
    .err_invalid_ptxt_char (err_invalid_ptxt_char),
    .busy                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cycleCount);
    end
  endtask

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic hi;
    p = 8'h00;
    for (int t = 0; t < 8; t++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a ^= 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] refRotl(input logic [7:0] x, input int n);
    for (int r = 0; r < n; r++) x = {x[6:0], x[7]};
    return x;
  endfunction

  function automatic logic [7:0] refSbox(input logic [7:0] x);
    logic [7:0] inv, base, s;
    int e;
    inv  = 8'h01;
    base = x;
    e    = 254;
    while (e > 0) begin
      if (e % 2 == 1) inv = gfMul(inv, base);
      base = gfMul(base, base);
      e    = e / 2;
    end
    s = inv;
    for (int r = 1; r <= 4; r++) s ^= refRotl(inv, r);
    return s ^ 8'h63;
  endfunction

  task automatic modelReset();
    for (int b = 0; b < 8; b++) modelH[b] = IV[8*b +: 8];
  endtask

  task automatic modelAbsorb(input logic [7:0] c);
    int i;
    for (int j = 0; j < 8 * ROUNDS; j++) begin
      i = j % 8;
      modelH[i] = refTable[refRotl(modelH[(i + 2) % 8] ^ c, i)];
    end
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_m_ready"}, m_ready, 1);
    checkOutput({pfx, "_digest_valid"}, digest_valid, 0);
    checkOutput({pfx, "_digest_char"}, digest_char, 0);
    checkOutput({pfx, "_digest_last"}, digest_last, 0);
    checkOutput({pfx, "_hash_ready"}, hash_ready, 0);
    checkOutput({pfx, "_err"}, err_invalid_ptxt_char, 0);
    checkOutput({pfx, "_busy"}, busy, 0);
  endtask

  // Presents one byte, waits for the handshake and returns the cycle it happened in
  task automatic applyStimulus(input logic [7:0] c, input logic last, output int hsAt);
    int n;
    n = 0;
    @(negedge clk);
    m_valid   = 1'b1;
    ptxt_char = c;
    m_last    = last;
    while (!m_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("hs_budget", n < 2000, 1);
    hsAt = cycleCount;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
  endtask

  task automatic waitDigest(output int absorbCycles);
    int n;
    absorbCycles = 0;
    n = 0;
    @(negedge clk);
    while (!digest_valid && n < 2000) begin
      if (!m_ready) absorbCycles++;
      @(negedge clk);
      n++;
    end
    checkOutput("digest_start", digest_valid, 1);
  endtask

  task automatic receiveDigest(input logic randomReady, input logic errExp);
    int k, n, firstCyc, lastCyc;
    k = 0;
    n = 0;
    firstCyc = 0;
    lastCyc  = 0;
    while (k < 8 && n < 400) begin
      if (randomReady) digest_ready = (n == 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
      else digest_ready = 1'b1;
      #1;
      checkOutput("digest_valid", digest_valid, 1);
      checkOutput("digest_char", digest_char, modelH[k]);
      checkOutput("digest_last", digest_last, k == 7);
      checkOutput("hash_ready", hash_ready, digest_ready && k == 7);
      checkOutput("err_hold", err_invalid_ptxt_char, errExp);
      if (digest_ready) begin
        if (k == 0) firstCyc = cycleCount;
        lastCyc = cycleCount;
        k++;
      end
      @(negedge clk);
      n++;
    end
    checkOutput("digest_budget", k, 8);
    if (!randomReady) checkOutput("digest_consecutive", lastCyc - firstCyc, 7);
    digest_ready = 1'b0;
    #1;
    checkOutput("post_digest_valid", digest_valid, 0);
    checkOutput("post_hash_ready", hash_ready, 0);
    checkOutput("post_err", err_invalid_ptxt_char, 0);
    checkOutput("post_busy", busy, 0);
    checkOutput("post_m_ready", m_ready, 1);
  endtask

  // Streams "AbZ" with m_valid held high, swapping the byte only after each handshake
  task automatic runHeldMessage(input string tag);
    logic [7:0] msg [3];
    int hsAt [3];
    int idx, n;
    msg[0] = 8'h41;
    msg[1] = 8'h62;
    msg[2] = 8'h5A;
    idx = 0;
    n   = 0;
    @(negedge clk);
    m_valid   = 1'b1;
    ptxt_char = msg[0];
    m_last    = 1'b0;
    while (idx < 3 && n < 3000) begin
      if (m_ready) begin
        hsAt[idx] = cycleCount;
        @(posedge clk);
        #1;
        idx++;
        if (idx < 3) begin
          ptxt_char = msg[idx];
          m_last    = (idx == 2);
        end else begin
          m_valid = 1'b0;
        end
      end
      @(negedge clk);
      n++;
    end
    m_valid = 1'b0;
    checkOutput({tag, "_hs_count"}, idx, 3);
    if (idx == 3) begin
      checkOutput({tag, "_gap01"}, hsAt[1] - hsAt[0], HS_GAP);
      checkOutput({tag, "_gap12"}, hsAt[2] - hsAt[1], HS_GAP);
    end
  endtask

  initial begin
    int hsA, hsB, absorbCycles;
    rst_n        = 1'b0;
    m_valid      = 1'b0;
    m_last       = 1'b0;
    ptxt_char    = 8'h00;
    digest_ready = 1'b0;
    for (int v = 0; v < 256; v++) refTable[v] = refSbox(8'(v));
    modelReset();
    repeat (3) @(negedge clk);
    checkResetValues("in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkResetValues("idle");

    // 'a' as a one-byte message; a stray invalid byte is offered while the controller is busy
    applyStimulus(8'h61, 1'b1, hsA);
    m_valid   = 1'b1;
    ptxt_char = 8'h31;
    m_last    = 1'b1;
    waitDigest(absorbCycles);
    m_valid = 1'b0;
    checkOutput("absorb_len_a", absorbCycles, 8 * ROUNDS);
    modelAbsorb(8'h61);
    receiveDigest(1'b0, 1'b0);
    modelReset();

    // Empty message: invalid last byte yields the digest of IV with err held
    applyStimulus(8'h31, 1'b1, hsA);
    checkOutput("err_after_invalid", err_invalid_ptxt_char, 1);
    waitDigest(absorbCycles);
    checkOutput("absorb_len_empty", absorbCycles, 0);
    receiveDigest(1'b0, 1'b1);

    for (int rep = 0; rep < 2; rep++) begin
      runHeldMessage(rep == 0 ? "held1" : "held2");
      modelAbsorb(8'h41);
      modelAbsorb(8'h62);
      modelAbsorb(8'h5A);
      waitDigest(absorbCycles);
      receiveDigest(1'b0, 1'b0);
      modelReset();
    end

    // Invalid non-last byte then a letter, accepted back to back
    applyStimulus(8'h23, 1'b0, hsA);
    checkOutput("invalid_keeps_ready", m_ready, 1);
    checkOutput("invalid_sets_err", err_invalid_ptxt_char, 1);
    applyStimulus(8'h51, 1'b1, hsB);
    checkOutput("back_to_back", hsB - hsA, 1);
    modelAbsorb(8'h51);
    waitDigest(absorbCycles);
    receiveDigest(1'b0, 1'b1);
    modelReset();

    // "Hi" under random digest backpressure
    applyStimulus(8'h48, 1'b0, hsA);
    applyStimulus(8'h69, 1'b1, hsB);
    checkOutput("hi_gap", hsB - hsA, HS_GAP);
    modelAbsorb(8'h48);
    modelAbsorb(8'h69);
    waitDigest(absorbCycles);
    receiveDigest(1'b1, 1'b0);
    modelReset();

    // Asynchronous reset mid-absorb and mid-digest
    applyStimulus(8'h61, 1'b1, hsA);
    repeat (100) @(negedge clk);
    checkOutput("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkResetValues("abs_rst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h51, 1'b1, hsA);
    waitDigest(absorbCycles);
    digest_ready = 1'b1;
    repeat (3) @(negedge clk);
    digest_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkResetValues("out_rst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h78, 1'b1, hsA);
    modelAbsorb(8'h78);
    waitDigest(absorbCycles);
    checkOutput("absorb_len_x", absorbCycles, 8 * ROUNDS);
    receiveDigest(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
